adc_sequencer: RTL

Frame controller for the serial ADC front end. It sequences one conversion at a time: it drives chip-select, runs a bit counter over the frame, and shifts the ADC's serial output into a parallel sample. Each finished sample is presented on a valid/ready port to the capture buffer. It runs entirely in the `sclk` domain, which is the same clock forwarded to the ADC.

---
 rtl/adc_sequencer_if.sv | 39 +++
 rtl/adc_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sequencer_if.sv
// adc_sequencer_if
// Sample hand-off port between the ADC frame sequencer and the capture buffer.
// The sequencer drives through the master modport and the capture buffer
// consumes through the slave modport.
// Optional feature macro: ADC_OVERRUN_EN adds the sticky overrun flag and its clear.

interface adc_sequencer_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
`ifdef ADC_OVERRUN_EN
    logic              overrun;
    logic              overrun_clr;
`endif

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
`ifdef ADC_OVERRUN_EN
        ,
        output overrun,
        input  overrun_clr
`endif
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
`ifdef ADC_OVERRUN_EN
        ,
        input  overrun,
        output overrun_clr
`endif
    );
endinterface

// File: rtl/adc_sequencer.sv
// adc_sequencer
// Frame controller for the serial ADC front end. It runs one conversion at a
// time in the sclk domain: it drops cs_n for FRAME_LEN cycles, counts the bits
// of the frame, discards the LEAD_ZEROS leading bits and shifts the remaining
// DATA_W bits in MSB first. Each finished word goes to a one-entry valid/ready
// output stage. Between frames cs_n stays high for QUIET_CYCLES cycles.
// Optional feature macro: ADC_OVERRUN_EN
//   defined   : a word completing while the stage is full overwrites it and
//               sets a sticky overrun flag (cleared by overrun_clr, set wins).
//   undefined : such a word is dropped and the stored sample is kept.

module adc_sequencer #(
    parameter int DATA_W       = 12,
    parameter int LEAD_ZEROS   = 4,
    parameter int FRAME_LEN    = 16,
    parameter int QUIET_CYCLES = 2
) (
    input  logic            sclk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            start,
    input  logic            sdata,
    output logic            cs_n,
    output logic            busy,
    adc_sequencer_if.master smp
);

    // FRAME_LEN must equal DATA_W + LEAD_ZEROS and be at most 32;
    // QUIET_CYCLES must lie in 1..15 so it fits the 4-bit quiet counter.
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(LEAD_ZEROS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [3:0]       QUIET_LAST = 4'(QUIET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_QUIET   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  bit_cnt_s;
    logic [3:0]        quiet_cnt_r;
    logic [3:0]        quiet_cnt_s;

    // Only DATA_W-1 bits need to be stored: the last data bit is taken
    // straight from sdata on the final edge of the frame.
    logic [DATA_W-2:0] shift_r;
    logic [DATA_W-2:0] shift_s;

    logic              word_done_s;
    logic [DATA_W-1:0] word_s;

    logic              cs_n_r;
    logic              busy_r;

    logic [DATA_W-1:0] sample_r;
    logic [DATA_W-1:0] sample_s;
    logic              sample_valid_r;
    logic              sample_valid_s;
    logic              accept_s;
    logic              overrun_evt_s;

    // Next-state logic for the frame FSM, bit counter, quiet counter and shifter.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        quiet_cnt_s = quiet_cnt_r;
        shift_s     = shift_r;
        word_done_s = 1'b0;
        word_s      = {shift_r, sdata};

        case (state_r)
            ST_IDLE: begin
                bit_cnt_s   = CNT_ZERO;
                quiet_cnt_s = 4'd0;
                if (enable || start) begin
                    state_s = ST_CONVERT;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CONVERT: begin
                // Leading bits are clocked past without touching the shifter.
                if (bit_cnt_r >= FIRST_DATA) begin
                    shift_s = {shift_r[DATA_W-3:0], sdata};
                end else begin
                    shift_s = shift_r;
                end

                if (bit_cnt_r == LAST_BIT) begin
                    word_done_s = 1'b1;
                    state_s     = ST_QUIET;
                    bit_cnt_s   = CNT_ZERO;
                    quiet_cnt_s = 4'd0;
                end else begin
                    state_s   = ST_CONVERT;
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                end
            end

            ST_QUIET: begin
                bit_cnt_s = CNT_ZERO;
                // enable is looked at only on the last quiet edge; start is
                // ignored here and never remembered.
                if (quiet_cnt_r == QUIET_LAST) begin
                    quiet_cnt_s = 4'd0;
                    if (enable) begin
                        state_s = ST_CONVERT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    quiet_cnt_s = quiet_cnt_r + 4'd1;
                    state_s     = ST_QUIET;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                bit_cnt_s   = CNT_ZERO;
                quiet_cnt_s = 4'd0;
            end
        endcase
    end

    // State, counters, shifter and the registered cs_n/busy outputs.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= CNT_ZERO;
            quiet_cnt_r <= 4'd0;
            shift_r     <= {(DATA_W-1){1'b0}};
            cs_n_r      <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            quiet_cnt_r <= quiet_cnt_s;
            shift_r     <= shift_s;
            // Decoded from the next state so both pins come straight off flops.
            cs_n_r      <= (state_s != ST_CONVERT);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Output stage decisions: load a finished word, retire an accepted one.
    always_comb begin
        sample_s       = sample_r;
        sample_valid_s = sample_valid_r;
        accept_s       = sample_valid_r && smp.sample_ready;
        overrun_evt_s  = 1'b0;

        if (word_done_s) begin
            if (!sample_valid_r || accept_s) begin
                sample_s       = word_s;
                sample_valid_s = 1'b1;
            end else begin
                // Stage still full and not being drained: overrun.
                overrun_evt_s  = 1'b1;
                sample_valid_s = 1'b1;
`ifdef ADC_OVERRUN_EN
                sample_s       = word_s;
`else
                sample_s       = sample_r;
`endif
            end
        end else if (accept_s) begin
            sample_valid_s = 1'b0;
        end else begin
            sample_valid_s = sample_valid_r;
        end
    end

    // Output stage registers.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            sample_r       <= {DATA_W{1'b0}};
            sample_valid_r <= 1'b0;
        end else begin
            sample_r       <= sample_s;
            sample_valid_r <= sample_valid_s;
        end
    end

`ifdef ADC_OVERRUN_EN
    logic overrun_r;

    // Sticky overrun flag; a new overrun on the clearing edge keeps it set.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (overrun_evt_s) begin
            overrun_r <= 1'b1;
        end else if (smp.overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign smp.overrun = overrun_r;
`else
    // Without the flag an overrun simply drops the new word.
    logic unused_overrun_s;
    assign unused_overrun_s = overrun_evt_s;
`endif

    assign cs_n             = cs_n_r;
    assign busy             = busy_r;
    assign smp.sample       = sample_r;
    assign smp.sample_valid = sample_valid_r;

endmodule
